// File: rtl/id_operand_scoreboard_pkg.sv
// Shared definitions for the ID-stage operand unit: forwarding source record
// and the issue latencies of the multi-cycle producers.
package id_operand_scoreboard_pkg;

    localparam int CPU_AW = 5;
    localparam int CPU_DW = 32;

    typedef struct packed {
        logic              valid;
        logic [CPU_AW-1:0] dst;
        logic [CPU_DW-1:0] data;
    } fwd_src_t;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MFC0 = 1;

endpackage

// File: rtl/id_operand_scoreboard_fwd_mux.sv
// Priority forwarding select: the youngest matching stage wins, otherwise the
// register file value; register 0 always resolves to zero.
module id_operand_scoreboard_fwd_mux
    import id_operand_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int AW     = CPU_AW,
    parameter int DW     = CPU_DW
) (
    input  logic [AW-1:0]        src,
    input  logic [DW-1:0]        rf_data,
    input  logic [NSTAGE-1:0]    fwd_valid,
    input  logic [NSTAGE*AW-1:0] fwd_dst,
    input  logic [NSTAGE*DW-1:0] fwd_data,
    output logic [DW-1:0]        data_o
);

    always_comb begin
        data_o = rf_data;
        // Walk from oldest to youngest so the youngest match is assigned last.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dst[i*AW +: AW] == src)) begin
                data_o = fwd_data[i*DW +: DW];
            end
        end
        if (src == '0) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand unit: register file, two forwarded read ports and a
// per-register latency scoreboard that raises load-use style stalls.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int DW     = CPU_DW,
    parameter int NSTAGE = 4,
    parameter int MAXLAT = 3,
    parameter int AW     = $clog2(NREG),
    parameter int LW     = $clog2(MAXLAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic                 id_fire,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic                 rs_read,
    input  logic                 rt_read,
    input  logic [AW-1:0]        dst,
    input  logic                 dst_wr,
    input  logic [LW-1:0]        dst_lat,
    input  logic [NSTAGE-1:0]    fwd_valid,
    input  logic [NSTAGE*AW-1:0] fwd_dst,
    input  logic [NSTAGE*DW-1:0] fwd_data,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_dst,
    input  logic [DW-1:0]        wb_data,
    output logic [DW-1:0]        bus_a,
    output logic [DW-1:0]        bus_b,
    output logic                 stall,
    output logic                 stall_rs,
    output logic                 stall_rt
);

    logic [DW-1:0] rf_q   [NREG];
    logic [DW-1:0] rf_d   [NREG];
    logic [LW-1:0] busy_q [NREG];
    logic [LW-1:0] busy_d [NREG];
    logic          sb_set;

    // rf_d already carries this cycle's write, so reading it gives write-through.
    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_dst != '0)) begin
            rf_d[wb_dst] = wb_data;
        end
    end

    always_comb begin
        stall_rs = id_valid && rs_read && (rs != '0) && (busy_q[rs] != '0);
        stall_rt = id_valid && rt_read && (rt != '0) && (busy_q[rt] != '0);
        stall    = stall_rs | stall_rt;
        sb_set   = id_fire && !stall && dst_wr && (dst != '0);
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LW'(1) : '0;
            if (sb_set && (dst == AW'(r))) begin
                busy_d[r] = dst_lat;
            end
            if (flush) begin
                busy_d[r] = '0;
            end
        end
        busy_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q   <= '{default: '0};
            busy_q <= '{default: '0};
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    id_operand_scoreboard_fwd_mux #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW)) u_fwd_a (
        .src       (rs),
        .rf_data   (rf_d[rs]),
        .fwd_valid (fwd_valid),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .data_o    (bus_a)
    );

    id_operand_scoreboard_fwd_mux #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW)) u_fwd_b (
        .src       (rt),
        .rf_data   (rf_d[rt]),
        .fwd_valid (fwd_valid),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .data_o    (bus_b)
    );

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Randomized and directed bench for id_operand_scoreboard with a queue-based
// scoreboard fed by a ready-time reference model.
module tb_id_operand_scoreboard;
    import id_operand_scoreboard_pkg::*;

    logic         clk = 1'b0;
    logic         rst, flush, id_valid, id_fire, rs_read, rt_read, dst_wr, wb_we;
    logic [4:0]   rs, rt, dst, wb_dst;
    logic [1:0]   dst_lat;
    logic [3:0]   fwd_valid;
    logic [19:0]  fwd_dst;
    logic [127:0] fwd_data;
    logic [31:0]  wb_data;
    logic [31:0]  bus_a, bus_b;
    logic         stall, stall_rs, stall_rt;

    fwd_src_t fs [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fwd_valid[i]          = fs[i].valid;
            fwd_dst[i*5 +: 5]     = fs[i].dst;
            fwd_data[i*32 +: 32]  = fs[i].data;
        end
    end

    id_operand_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_fire(id_fire),
        .rs(rs), .rt(rt), .rs_read(rs_read), .rt_read(rt_read),
        .dst(dst), .dst_wr(dst_wr), .dst_lat(dst_lat),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .bus_a(bus_a), .bus_b(bus_b), .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        stall;
        logic        srs;
        logic        srt;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    vectors = 0;
    int    miscompares = 0;

    // Reference model: a register is busy until the cycle its result is ready.
    logic [31:0] m_rf [32];
    int          m_ready [32];
    int          m_cyc = 0;

    function automatic logic [31:0] m_operand(input logic [4:0] s);
        if (s == 0) return 32'h0;
        for (int i = 0; i < 4; i++)
            if (fs[i].valid && fs[i].dst == s) return fs[i].data;
        if (wb_we && wb_dst == s) return wb_data;
        return m_rf[s];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && (m_ready[r] > m_cyc);
    endfunction

    task automatic idle();
        flush = 0; id_valid = 0; id_fire = 0; rs = 0; rt = 0; rs_read = 0; rt_read = 0;
        dst = 0; dst_wr = 0; dst_lat = 0; wb_we = 0; wb_dst = 0; wb_data = 0;
        for (int i = 0; i < 4; i++) fs[i] = '0;
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        e.a     = m_operand(rs);
        e.b     = m_operand(rt);
        e.srs   = id_valid && rs_read && m_busy(rs);
        e.srt   = id_valid && rt_read && m_busy(rt);
        e.stall = e.srs | e.srt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[r] = 0;
                m_ready[r] = 0;
            end
        end else begin
            if (wb_we && wb_dst != 0) m_rf[wb_dst] = wb_data;
            if (id_fire && !e.stall && dst_wr && dst != 0) m_ready[dst] = m_cyc + 1 + int'(dst_lat);
            if (flush) for (int r = 0; r < 32; r++) m_ready[r] = 0;
        end
        m_cyc++;
        #1;
    endtask

    task automatic fire(input logic [4:0] d, input int lat);
        idle();
        id_valid = 1; id_fire = 1; dst_wr = 1; dst = d; dst_lat = 2'(lat);
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                vectors++;
                if ({bus_a, bus_b, stall, stall_rs, stall_rt} !== e) begin
                    miscompares++;
                    $display("FAIL %s: got a=%h b=%h stall=%b/%b/%b, want a=%h b=%h stall=%b/%b/%b",
                             t, bus_a, bus_b, stall, stall_rs, stall_rt,
                             e.a, e.b, e.stall, e.srs, e.srt);
                end
            end
        end
    end

    initial begin : stim
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 0;
            m_ready[r] = 0;
        end
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cycle("reset");
        rst = 0;

        // Reset clears a previously written register.
        wb_we = 1; wb_dst = 3; wb_data = 32'hDEADBEEF;
        cycle("wb_r3");
        idle(); id_valid = 1; rs = 3; rs_read = 1;
        cycle("r3_before_rst");
        rst = 1;
        cycle("r3_in_rst");
        rst = 0;
        cycle("r3_after_rst");

        // Priority forwarding.
        idle(); rs = 7; rt = 7;
        fs[0] = '{valid: 1'b1, dst: 5'd7, data: 32'h11};
        fs[2] = '{valid: 1'b1, dst: 5'd7, data: 32'h33};
        cycle("prio_young");
        fs[0].valid = 0;
        cycle("prio_old");

        // Load-use.
        fire(5, LAT_LOAD);
        cycle("lu_fire");
        idle(); id_valid = 1; id_fire = 1; rt = 5; rt_read = 1; dst = 5; dst_wr = 1; dst_lat = 2'd3;
        cycle("lu_stall1");
        cycle("lu_stall2");
        fs[1] = '{valid: 1'b1, dst: 5'd5, data: 32'hCAFE0005};
        cycle("lu_go");

        // WAW override by a later zero-latency producer.
        fire(9, 3);
        cycle("waw_first");
        fire(9, LAT_ALU);
        cycle("waw_second");
        idle(); id_valid = 1; rs = 9; rs_read = 1;
        cycle("waw_read");

        // Flush clears pending latency.
        fire(4, 3);
        cycle("fl_fire");
        idle(); flush = 1;
        cycle("fl_edge");
        idle(); id_valid = 1; rs = 4; rs_read = 1;
        cycle("fl_read");
        fire(4, 3); flush = 1;
        cycle("fl_vs_set");
        idle(); id_valid = 1; rt = 4; rt_read = 1;
        cycle("fl_vs_set_read");

        // Register 0 and write-through.
        fire(0, 3);
        cycle("r0_fire");
        idle(); id_valid = 1; rs = 0; rs_read = 1;
        fs[0] = '{valid: 1'b1, dst: 5'd0, data: 32'hFFFF0000};
        cycle("r0_read");
        idle(); wb_we = 1; wb_dst = 6; wb_data = 32'h55; rs = 6; id_valid = 1; rs_read = 1;
        cycle("wthru");
        idle(); wb_we = 1; wb_dst = 0; wb_data = 32'h77; rs = 0; rt = 0;
        cycle("wb_r0");

        // MFC0 latency: one stall cycle on rs.
        fire(12, LAT_MFC0);
        cycle("mfc0_fire");
        idle(); id_valid = 1; id_fire = 1; rs = 12; rs_read = 1;
        cycle("mfc0_stall");
        cycle("mfc0_go");

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            id_fire  = id_valid && ($urandom_range(0, 1) == 1);
            rs       = 5'($urandom_range(0, 7));
            rt       = 5'($urandom_range(0, 7));
            rs_read  = 1'($urandom);
            rt_read  = 1'($urandom);
            dst      = 5'($urandom_range(0, 7));
            dst_wr   = 1'($urandom);
            dst_lat  = 2'($urandom_range(0, 3));
            wb_we    = 1'($urandom);
            wb_dst   = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            for (int i = 0; i < 4; i++) begin
                fs[i].valid = ($urandom_range(0, 2) == 0);
                fs[i].dst   = 5'($urandom_range(0, 7));
                fs[i].data  = $urandom;
            end
            cycle("random");
        end

        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_operand_scoreboard.md
Name: id_operand_scoreboard

Overview:
Parametrised ID-stage operand unit that generalises the fixed EXE/MEM/MEM2/WB bypass and load-use hazard logic.
- Contains the architectural register file (NREG x DW), two source read ports, and an N-stage priority forwarding network.
- A per-register latency scoreboard replaces stage-by-stage rt/ReadMEM comparison, so new multi-cycle producers (loads, MFC0, MUL) need no new hazard wiring.
- Sits between the IF/ID register and the ID/EXE interface.

Parameters:
NREG, 32, number of architectural registers; register 0 reads as zero.
DW, 32, data width.
NSTAGE, 4, number of forwarding sources; index 0 is youngest (EXE), NSTAGE-1 is oldest (WB).
MAXLAT, 3, maximum producer latency in cycles.
AW, $clog2(NREG), register index width (derived).
LW, $clog2(MAXLAT+1), latency field width (derived).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active high.
flush  in  1  pipeline flush; clears the scoreboard.
id_valid  in  1  ID holds a valid instruction.
id_fire  in  1  ID instruction advances to EXE this cycle.
rs, rt  in  AW each  source register indices.
rs_read, rt_read  in  1 each  source is actually used.
dst  in  AW  destination of the ID instruction.
dst_wr  in  1  ID instruction writes dst.
dst_lat  in  LW  cycles until the result is forwardable from some stage (0 = available from EXE next cycle).
fwd_valid  in  NSTAGE  stage holds a forwardable result.
fwd_dst  in  NSTAGE*AW  per-stage destination.
fwd_data  in  NSTAGE*DW  per-stage result.
wb_we  in  1  register file write enable.
wb_dst  in  AW  write index.
wb_data  in  DW  write data.
bus_a, bus_b  out  DW each  resolved operands.
stall  out  1  data-hazard stall request.
stall_rs, stall_rt  out  1 each  per-source hazard flags (debug/perf counters).

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active high (rst), sampled on the rising edge.
- On rst: all RF entries = 0; all busy counters = 0. Outputs then: stall = 0, stall_rs = stall_rt = 0; bus_a/bus_b = 0 unless a forwarding source matches.

Register file:
- Written on the rising edge when wb_we && wb_dst != 0.
- Writes to register 0 are dropped.
- Read is asynchronous. Same-cycle write/read of the same index returns wb_data (internal write-through).

Forwarding (combinational), per source s:
- s == 0 -> 0.
- Otherwise the lowest index i with fwd_valid[i] && fwd_dst[i] == s supplies fwd_data[i].
- Otherwise the RF value is used.
- Younger stages always win over older ones.

Scoreboard:
- One counter busy[r] of LW bits per register; busy[0] is always 0.
- Set: on a clock edge with id_fire && !stall && dst_wr && dst != 0, busy[dst] <= dst_lat.
- Every other r with busy[r] != 0 decrements by 1 each cycle.
- A set on the same edge overrides the decrement (WAW: the later producer wins).
- id_fire while stall = 1 is ignored and sets nothing.
- flush: all counters go to 0 at the edge, taking priority over a simultaneous set.
- rst mid-operation: same as flush, and the RF is also cleared.

Hazard:
- stall_rs = id_valid && rs_read && rs != 0 && busy[rs] != 0; stall_rt is analogous.
- stall = stall_rs | stall_rt.
- Timing rule: a dependent instruction sitting in ID the cycle after a producer issues with latency L stalls for exactly L cycles. It reads the forwarded value on the first non-stalled cycle.
- dst_lat = 0 never stalls; plain bypass from EXE covers it.
- Counters saturate at 0 and never wrap.

Decomposition:
- Shared package (CPU_Defines): fwd_src_t struct {valid, dst, data}; scoreboard latency constants LAT_ALU = 0, LAT_LOAD = 2, LAT_MFC0 = 1.
- Sub-module fwd_mux: parametrised NSTAGE-input priority select, instantiated twice (bus_a, bus_b).
- RF storage and scoreboard counters stay in the top module.

Test Plan:
- Reset: write r3 = 0xDEADBEEF via WB, assert rst, read rs = 3 -> bus_a = 0; stall = 0.
- Priority forward: fwd_valid = 4'b0101, fwd_dst[0] = fwd_dst[2] = 7, data 0x11 / 0x33, rs = 7 -> bus_a = 0x11; drop fwd_valid[0] -> 0x33.
- Load-use: fire dst = 5, lat = 2 at cycle t; instruction reading rt = 5 in ID at t+1 -> stall = 1 at t+1 and t+2, stall = 0 at t+3 with bus_b = fwd_data from the matching stage.
- WAW override: fire dst = 9 lat = 3, next cycle fire dst = 9 lat = 0 -> reader of r9 does not stall the following cycle.
- Flush: fire dst = 4 lat = 3, assert flush next edge -> reader of r4 sees stall = 0 immediately after.
- Register 0 and write-through: fire dst = 0 lat = 3 -> no stall on rs = 0, bus_a = 0. wb_we with wb_dst = 6, data 0x55, and rs = 6 in the same cycle with no forward match -> bus_a = 0x55.
